// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - 4-bit opcode values for the single-cycle and iterative operations
//   - FSM state encoding of the multi-cycle controller
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle between the control FSM and alu_mc.
//   start, ALUctl, A, B      : request, driven by the master
//   busy, done               : progress/completion, driven by the ALU
//   ALUout, Overflow, Zero,
//   DivByZero                : registered result and flags
//   dbg_state                : current controller state, for observation
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// Operands and opcode are captured on that edge; start while busy=1 is
// dropped, not queued. done is a one-cycle pulse marking the cycle in which
// the new ALUout and flags are first visible; they then hold until the
// next accepted request completes. A start during the done cycle is legal.
interface alu_mc_if #(parameter int W = 11);
    logic         start;
    logic [3:0]   ALUctl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] ALUout;
    logic         Overflow;
    logic         Zero;
    logic         DivByZero;
    logic [1:0]   dbg_state;

    modport master (
        output start, ALUctl, A, B,
        input  busy, done, ALUout, Overflow, Zero, DivByZero, dbg_state
    );

    modport slave (
        input  start, ALUctl, A, B,
        output busy, done, ALUout, Overflow, Zero, DivByZero, dbg_state
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational W-bit single-cycle ALU.
//   ALUctl   in  opcode (AND, OR, ADD, SUB, SLT, NOR; anything else -> 0)
//   A, B     in  operands
//   ALUout   out result
//   Overflow out signed overflow for ADD/SUB, 0 otherwise
//   Zero     out ALUout == 0
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 11
) (
    input  logic [3:0]   ALUctl,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] ALUout,
    output logic         Overflow,
    output logic         Zero
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         add_ovf;
    logic         sub_ovf;

    assign sum  = A + B;
    assign diff = A - B;

    // Two's-complement overflow: the result sign disagrees with what the
    // operand signs force it to be.
    assign add_ovf = (A[W-1] == B[W-1]) && (sum[W-1]  != A[W-1]);
    assign sub_ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);

    always_comb begin
        ALUout   = '0;
        Overflow = 1'b0;
        case (ALUctl)
            OP_AND: ALUout = A & B;
            OP_OR:  ALUout = A | B;
            OP_NOR: ALUout = ~(A | B);
            OP_ADD: begin
                ALUout   = sum;
                Overflow = add_ovf;
            end
            OP_SUB: begin
                ALUout   = diff;
                Overflow = sub_ovf;
            end
            // Sign of A-B is wrong exactly when the subtraction overflows.
            OP_SLT: ALUout = {{(W-1){1'b0}}, diff[W-1] ^ sub_ovf};
            default: ;
        endcase
    end

    assign Zero = (ALUout == '0);

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle W-bit ALU with registered outputs.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : alu_mc_if slave (request, busy/done, result, flags)
// Single-cycle ops and divide-by-zero complete on the accepting edge.
// MUL (shift-add) and DIVU/REMU (restoring) run W iterations, one per edge,
// and complete W edges after acceptance.
module alu_mc
    import alu_pkg::*;
#(
    parameter int W = 11
) (
    input  logic     clock,
    input  logic     reset,
    alu_mc_if.slave  bus
);

    localparam int CW = $clog2(W);

    logic [1:0]     state;
    logic [1:0]     state_next;
    logic [CW-1:0]  cnt;
    // {high, low}: MUL = {partial product, remaining multiplier bits},
    // DIV = {partial remainder, dividend bits shifting into quotient}.
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV)
    logic           is_rem;

    logic           accept;
    logic           last;
    logic           is_div_op;
    logic           div_zero;

    logic [W-1:0]   core_out;
    logic           core_ovf;
    logic           core_zero;

    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [W-1:0]   div_sub;
    logic           div_ge;
    logic [W-1:0]   iter_out;
    logic           iter_ovf;
    logic [W-1:0]   dz_out;

    logic [W-1:0]   res_q;
    logic           ovf_q;
    logic           zero_q;
    logic           dbz_q;
    logic           done_q;

    alu_core #(.W(W)) u_core (
        .ALUctl   (bus.ALUctl),
        .A        (bus.A),
        .B        (bus.B),
        .ALUout   (core_out),
        .Overflow (core_ovf),
        .Zero     (core_zero)
    );

    assign is_div_op = (bus.ALUctl == OP_DIVU) || (bus.ALUctl == OP_REMU);
    assign div_zero  = is_div_op && (bus.B == '0);
    assign dz_out    = (bus.ALUctl == OP_DIVU) ? '1 : bus.A;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.ALUctl == OP_MUL)       state_next = ST_MUL;
                    else if (is_div_op && !div_zero) state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: if (last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        accept        = bus.start && (state == ST_IDLE);
        last          = (cnt == CW'(W - 1));
        bus.busy      = (state != ST_IDLE);
        bus.dbg_state = state;
    end

    // One iteration step of the shift register.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        div_trial = {acc[2*W-1:W], acc[W-1]};
        div_ge    = (div_trial >= {1'b0, opnd});
        // The true difference is below the divisor, so W bits hold it.
        div_sub   = div_trial[W-1:0] - opnd;
        acc_next  = acc;
        case (state)
            ST_MUL: acc_next = acc[0] ? {mul_sum, acc[W-1:1]}
                                      : {1'b0, acc[2*W-1:1]};
            ST_DIV: acc_next = {(div_ge ? div_sub : div_trial[W-1:0]),
                                acc[W-2:0], div_ge};
            default: ;
        endcase
        iter_out = ((state == ST_DIV) && is_rem) ? acc_next[2*W-1:W]
                                                 : acc_next[W-1:0];
        iter_ovf = (state == ST_MUL) && (acc_next[2*W-1:W] != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_rem <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cnt <= '0;
                if (bus.ALUctl == OP_MUL) begin
                    opnd <= bus.A;
                    acc  <= {{W{1'b0}}, bus.B};
                end else if (div_zero) begin
                    res_q  <= dz_out;
                    ovf_q  <= 1'b0;
                    zero_q <= (dz_out == '0);
                    dbz_q  <= 1'b1;
                    done_q <= 1'b1;
                end else if (is_div_op) begin
                    opnd   <= bus.B;
                    acc    <= {{W{1'b0}}, bus.A};
                    is_rem <= (bus.ALUctl == OP_REMU);
                end else begin
                    res_q  <= core_out;
                    ovf_q  <= core_ovf;
                    zero_q <= core_zero;
                    dbz_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (state != ST_IDLE) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    res_q  <= iter_out;
                    ovf_q  <= iter_ovf;
                    zero_q <= (iter_out == '0);
                    dbz_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ALUout    = res_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Zero      = zero_q;
    assign bus.DivByZero = dbz_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc at W=11.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 11;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_mc_if #(.W(W)) bus ();

    alu_mc #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issue one request, wait for done (bounded), check latency and result.
    // With intrude=1 an ADD request is raised while the op is still busy.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_out, input logic exp_ovf,
                          input logic exp_dbz, input int exp_lat,
                          input bit intrude);
        int cycles;
        logic [W-1:0] exp_v;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.ALUctl = op;
        bus.A      = a;
        bus.B      = b;
        exp_q.push_back(exp_out);
        @(posedge clock);
        #1;
        // Scramble inputs: operands must have been latched already.
        bus.start  = 1'b0;
        bus.A      = W'($urandom_range(0, 2047));
        bus.B      = W'($urandom_range(0, 2047));
        bus.ALUctl = 4'($urandom_range(0, 15));
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (cycles == 1) begin
                check({tag, "_busy"}, 32'(bus.busy), 32'(1));
                check({tag, "_state"}, 32'(bus.dbg_state),
                      32'((op == OP_MUL) ? ST_MUL : ST_DIV));
            end
            if (intrude && cycles == 3) begin
                bus.start  = 1'b1;
                bus.ALUctl = OP_ADD;
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge clock);
            #1;
            cycles++;
        end
        bus.start = 1'b0;
        exp_v = exp_q.pop_front();
        check({tag, "_lat"},  32'(cycles),        32'(exp_lat));
        check({tag, "_out"},  32'(bus.ALUout),    32'(exp_v));
        check({tag, "_ovf"},  32'(bus.Overflow),  32'(exp_ovf));
        check({tag, "_zero"}, 32'(bus.Zero),      32'(exp_v == '0));
        check({tag, "_dbz"},  32'(bus.DivByZero), 32'(exp_dbz));
        check({tag, "_busy0"}, 32'(bus.busy),     32'(0));
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, 32'(bus.done), 32'(0));
    endtask

    initial begin : main
        int pulses;
        bus.start  = 1'b0;
        bus.ALUctl = 4'b0000;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",  32'(bus.busy),      32'(0));
        check("rst_done",  32'(bus.done),      32'(0));
        check("rst_out",   32'(bus.ALUout),    32'(0));
        check("rst_zero",  32'(bus.Zero),      32'(1));
        check("rst_ovf",   32'(bus.Overflow),  32'(0));
        check("rst_dbz",   32'(bus.DivByZero), 32'(0));
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // single-cycle ops
        run_op("or",    OP_OR,  11'd1036, 11'd3,    11'd1039, 1'b0, 1'b0, 1, 1'b0);
        run_op("add",   OP_ADD, 11'd1023, 11'd1,    11'd1024, 1'b1, 1'b0, 1, 1'b0);
        run_op("sub",   OP_SUB, 11'd5,    11'd5,    11'd0,    1'b0, 1'b0, 1, 1'b0);
        run_op("subov", OP_SUB, 11'd1024, 11'd1,    11'd1023, 1'b1, 1'b0, 1, 1'b0);
        run_op("and",   OP_AND, 11'd1036, 11'd3,    11'd0,    1'b0, 1'b0, 1, 1'b0);
        run_op("nor",   OP_NOR, 11'd0,    11'd0,    11'd2047, 1'b0, 1'b0, 1, 1'b0);
        run_op("slt1",  OP_SLT, 11'd2047, 11'd1,    11'd1,    1'b0, 1'b0, 1, 1'b0);
        run_op("slt2",  OP_SLT, 11'd1024, 11'd1023, 11'd1,    1'b0, 1'b0, 1, 1'b0);
        run_op("slt3",  OP_SLT, 11'd1023, 11'd1024, 11'd0,    1'b0, 1'b0, 1, 1'b0);
        run_op("inv",   4'b0011, 11'd7,   11'd9,    11'd0,    1'b0, 1'b0, 1, 1'b0);

        // iterative ops
        run_op("mul1",  OP_MUL,  11'd45,   11'd45,   11'd2025, 1'b0, 1'b0, 12, 1'b0);
        run_op("mul2",  OP_MUL,  11'd46,   11'd46,   11'd68,   1'b1, 1'b0, 12, 1'b1);
        run_op("mul3",  OP_MUL,  11'd2047, 11'd2047, 11'd1,    1'b1, 1'b0, 12, 1'b0);
        run_op("divu1", OP_DIVU, 11'd1036, 11'd3,    11'd345,  1'b0, 1'b0, 12, 1'b0);
        run_op("remu1", OP_REMU, 11'd1036, 11'd3,    11'd1,    1'b0, 1'b0, 12, 1'b0);
        run_op("divu2", OP_DIVU, 11'd5,    11'd7,    11'd0,    1'b0, 1'b0, 12, 1'b0);
        run_op("remu2", OP_REMU, 11'd5,    11'd7,    11'd5,    1'b0, 1'b0, 12, 1'b0);
        run_op("divu3", OP_DIVU, 11'd2047, 11'd1,    11'd2047, 1'b0, 1'b0, 12, 1'b0);
        run_op("remu3", OP_REMU, 11'd2047, 11'd2047, 11'd0,    1'b0, 1'b0, 12, 1'b0);

        // divide by zero
        run_op("dz_div", OP_DIVU, 11'd1036, 11'd0, 11'd2047, 1'b0, 1'b1, 1, 1'b0);
        run_op("dz_rem", OP_REMU, 11'd1036, 11'd0, 11'd1036, 1'b0, 1'b1, 1, 1'b0);
        run_op("dz_clr", OP_ADD,  11'd2,    11'd3, 11'd5,    1'b0, 1'b0, 1, 1'b0);

        // MUL interrupted by reset; ignored start at cycle 3
        @(negedge clock);
        bus.start  = 1'b1;
        bus.ALUctl = OP_MUL;
        bus.A      = 11'd45;
        bus.B      = 11'd45;
        @(posedge clock);
        #1;
        for (int i = 1; i < 5; i++) begin
            bus.start  = (i == 3);
            bus.ALUctl = (i == 3) ? OP_ADD : OP_MUL;
            check("int_nodone", 32'(bus.done), 32'(0));
            @(posedge clock);
            #1;
        end
        check("int_busy", 32'(bus.busy), 32'(1));
        // Reset together with a start: reset must win.
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.ALUctl = OP_ADD;
        bus.A      = 11'd1;
        bus.B      = 11'd1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("irst_busy",  32'(bus.busy),      32'(0));
        check("irst_done",  32'(bus.done),      32'(0));
        check("irst_out",   32'(bus.ALUout),    32'(0));
        check("irst_zero",  32'(bus.Zero),      32'(1));
        check("irst_ovf",   32'(bus.Overflow),  32'(0));
        check("irst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        pulses = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        check("irst_pulses", 32'(pulses), 32'(0));
        run_op("post_add", OP_ADD, 11'd100, 11'd200, 11'd300, 1'b0, 1'b0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the team's combinational W-bit ALU. It keeps the six single-cycle operations with their opcodes and flags, and adds iterative unsigned multiply, divide and remainder. A start/busy/done handshake is added and all outputs are registered. It sits between the datapath register file and the writeback mux, and is driven by the control FSM.

## Interface
Parameters:
- W, 11, operand/result width (W ≥ 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- ALUctl  in  4  opcode, sampled with start
- A  in  W  operand A, sampled with start
- B  in  W  operand B, sampled with start
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; result valid
- ALUout  out  W  registered result; held until the next accepted start
- Overflow  out  1  registered overflow flag
- Zero  out  1  registered; 1 when ALUout == 0
- DivByZero  out  1  registered; 1 when DIVU/REMU has B == 0

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100 (single-cycle)
  - MUL 1000, DIVU 1001, REMU 1010 (iterative)
- Any other opcode gives ALUout=0, Overflow=0 and Zero=1. It takes one cycle.
- ADD/SUB: modulo 2^W. Overflow is signed two's-complement overflow.
- SLT: signed compare, corrected for subtraction overflow. ALUout = {0…0, A<B}. Overflow=0.
- AND/OR/NOR: bitwise. Overflow=0.
- MUL: unsigned shift-add, one partial product per cycle. ALUout is the low W bits of A*B. Overflow=1 if the high W bits are nonzero.
- DIVU/REMU: unsigned restoring division, one quotient bit per cycle. ALUout is the quotient (DIVU) or the remainder (REMU). Overflow=0.
- Divide by zero: short-circuits in one cycle.
  - DIVU gives all ones. REMU gives A.
  - DivByZero=1.
- DivByZero=0 for every other completed operation.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL or DIV on an accepted start with an iterative opcode (and B≠0 for a divide).
  - MUL/DIV → IDLE when the iteration counter reaches W−1.
- Operands are latched at acceptance. Later changes on A, B and ALUctl have no effect.

## Timing
- Acceptance: start=1 at edge k while busy=0.
- Single-cycle ops and divide-by-zero: result and flags are written at edge k. done=1 and busy=0 during cycle k→k+1.
- MUL/DIV:
  - busy=1 from edge k to edge k+W.
  - Iterations run at edges k+1…k+W.
  - Result is written at edge k+W. done=1 and busy=0 during the following cycle.
  - Latency is W+1 cycles.
- done is a pulse. It clears at the next edge unless another op completes there.
- start while busy=1 is ignored and not queued.
- start during a done cycle is accepted (back-to-back ops).
- Reset at any edge, including mid-iteration, puts all of the following at 0: state=IDLE, busy, done, ALUout, Overflow, DivByZero, counter and partial registers. Zero=1. The interrupted op never signals done.
- Reset wins over a simultaneous start.

## Structure
- Package alu_pkg holds:
  - opcode localparams (AND, OR, ADD, SUB, SLT, NOR, MUL, DIVU, REMU)
  - state encoding localparams
- One sub-module, alu_core: the combinational W-bit single-cycle ALU (six ops, Overflow, Zero). It is instantiated once for the fast path.
- Top level holds the FSM, the ⌈log2 W⌉-bit iteration counter, the 2W-bit product/remainder shift register and the output registers.

## Test plan (W=11)
- OR, A=1036, B=3 → one cycle later done=1, ALUout=1039, Overflow=0, Zero=0.
- ADD, A=1023, B=1 → ALUout=1024, Overflow=1. SUB, A=5, B=5 → ALUout=0, Zero=1.
- MUL:
  - A=45, B=45 → done exactly 12 cycles after acceptance, ALUout=2025, Overflow=0.
  - A=46, B=46 → ALUout=68, Overflow=1.
- DIVU, A=1036, B=3 → ALUout=345 after 12 cycles. REMU with the same operands → ALUout=1.
- DIVU, A=1036, B=0 → done after 1 cycle, ALUout=2047, DivByZero=1. REMU → ALUout=1036.
- MUL started, then:
  - a second start at cycle 3 is ignored;
  - reset at cycle 5 → busy=0, ALUout=0, Zero=1, and no done pulse ever appears.
  - A new ADD after reset completes normally.
